// File: rtl/tdoa_localizer.sv
// tdoa_localizer: turns toward a tone source from the two-mic arrival delay, then drives forward; spins to search when idle.
module tdoa_localizer #(
  parameter int TIMER_W     = 16,
  parameter int TIMEOUT_CYC = 13000,
  parameter int EQUAL_WIN   = 0,
  parameter int GAIN        = 9000,
  parameter int MOVE_W      = 27,
  parameter int FWD_CYC     = 300000,
  parameter bit SEARCH_EN   = 1'b1,
  parameter int SEARCH_IDLE = 2**24 - 1,
  parameter int SEARCH_CYC  = 2**22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mic_a,
  input  logic       mic_b,
  input  logic       enable,
  output logic       direction,
  output logic       rotate,
  output logic       move,
  output logic [1:0] lead,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {IDLE, ARMED, ROTATE, FORWARD, SEARCH} stateT;
  localparam int IDLE_W = $clog2(SEARCH_IDLE + 1);
  localparam int PROD_W = TIMER_W + 32;
  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;
  localparam logic [TIMER_W-1:0] TIMEOUT = TIMER_W'(TIMEOUT_CYC);
  localparam logic [TIMER_W-1:0] EQ = TIMER_W'(EQUAL_WIN);
  localparam logic [MOVE_W-1:0] MOVE_MAX = '1;
  localparam logic [MOVE_W-1:0] FWD = MOVE_W'(FWD_CYC);
  localparam logic [MOVE_W-1:0] SRCH = MOVE_W'(SEARCH_CYC);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(SEARCH_IDLE - 1);

  stateT state, nxtState;
  logic [1:0] syncA, syncB, nxtLead;
  logic dlyA, dlyB, edgeA, edgeB, nearEq;
  logic [TIMER_W-1:0] timer, nxtTimer, tInc;
  logic [MOVE_W-1:0] count, nxtCount, rotCount;
  logic [IDLE_W-1:0] idleCnt, nxtIdle;
  logic [PROD_W-1:0] prod;

  // the cycle the second edge lands counts toward the delay
  assign tInc = (timer == TIMER_MAX) ? timer : timer + 1'b1;
  assign nearEq = tInc <= EQ;
  assign prod = PROD_W'(tInc) * PROD_W'(GAIN);
  assign rotCount = (prod > PROD_W'(MOVE_MAX)) ? MOVE_MAX : prod[MOVE_W-1:0];
  assign state_o = state;

  always_comb begin
    nxtState = state;
    nxtLead = lead;
    nxtTimer = timer;
    nxtCount = count;
    nxtIdle = '0;
    if (!enable) begin
      nxtState = IDLE;
      nxtLead = 2'b00;
      nxtTimer = '0;
      nxtCount = '0;
    end else if ((state == IDLE || state == SEARCH) && (edgeA || edgeB)) begin
      nxtState = (edgeA && edgeB) ? FORWARD : ARMED;
      nxtLead = {edgeB, edgeA};
      nxtTimer = '0;
      nxtCount = (edgeA && edgeB) ? FWD : '0;
    end else begin
      case (state)
        IDLE: begin
          if (SEARCH_EN && idleCnt == IDLE_LIM) begin
            nxtState = SEARCH;
            nxtCount = SRCH;
          end else nxtIdle = idleCnt + 1'b1;
        end
        ARMED: begin
          nxtTimer = tInc;
          if (edgeA && edgeB) begin
            nxtState = FORWARD;
            nxtLead = 2'b11;
            nxtCount = FWD;
          end else if ((edgeA && lead == 2'b10) || (edgeB && lead == 2'b01)) begin
            nxtState = nearEq ? FORWARD : ROTATE;
            nxtLead = nearEq ? 2'b11 : lead;
            nxtCount = nearEq ? FWD : rotCount;
          end else if (edgeA || edgeB) nxtTimer = '0;
          else if (tInc >= TIMEOUT) begin
            nxtState = IDLE;
            nxtLead = 2'b00;
            nxtTimer = '0;
          end
        end
        ROTATE: begin
          nxtState = (count <= 1) ? FORWARD : ROTATE;
          nxtCount = (count <= 1) ? FWD : count - 1'b1;
        end
        FORWARD: begin
          nxtState = (count <= 1) ? IDLE : FORWARD;
          nxtLead = (count <= 1) ? 2'b00 : lead;
          nxtCount = (count <= 1) ? '0 : count - 1'b1;
        end
        SEARCH: begin
          nxtState = (count <= 1) ? IDLE : SEARCH;
          nxtCount = (count <= 1) ? '0 : count - 1'b1;
        end
        default: nxtState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      syncA <= '0;
      syncB <= '0;
      dlyA <= 1'b0;
      dlyB <= 1'b0;
      edgeA <= 1'b0;
      edgeB <= 1'b0;
      state <= IDLE;
      lead <= 2'b00;
      timer <= '0;
      count <= '0;
      idleCnt <= '0;
      move <= 1'b0;
      rotate <= 1'b0;
      direction <= 1'b0;
    end else begin
      syncA <= {syncA[0], mic_a};
      syncB <= {syncB[0], mic_b};
      dlyA <= syncA[1];
      dlyB <= syncB[1];
      edgeA <= syncA[1] & ~dlyA;
      edgeB <= syncB[1] & ~dlyB;
      state <= nxtState;
      lead <= nxtLead;
      timer <= nxtTimer;
      count <= nxtCount;
      idleCnt <= nxtIdle;
      move <= nxtState inside {ROTATE, FORWARD, SEARCH};
      rotate <= nxtState inside {ROTATE, SEARCH};
      direction <= nxtState inside {FORWARD, SEARCH} || (nxtState == ROTATE && nxtLead == 2'b01);
    end
endmodule

// File: tb/tb_tdoa_localizer.sv
// tb_tdoa_localizer: scoreboard bench; expected motion episodes are queued at stimulus time and matched as the DUT moves.
module tb_tdoa_localizer;
  localparam int GAIN = 4;
  localparam int FWD_CYC = 10;
  localparam int TIMEOUT_CYC = 100;
  localparam int EQUAL_WIN = 0;
  localparam int SEARCH_IDLE = 50;
  localparam int SEARCH_CYC = 8;

  typedef struct {
    logic [1:0] lead;
    int rot;
    logic dir;
    int fwd;
  } episodeT;

  logic clk, rst_n, mic_a, mic_b, enable;
  logic direction, rotate, move;
  logic [1:0] lead;
  logic [2:0] state_o;
  episodeT expQ[$];
  int nChecks = 0, nPass = 0;
  bit monOn = 1;

  tdoa_localizer #(
    .GAIN(GAIN), .FWD_CYC(FWD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .EQUAL_WIN(EQUAL_WIN),
    .SEARCH_EN(1'b1), .SEARCH_IDLE(SEARCH_IDLE), .SEARCH_CYC(SEARCH_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mic_a(mic_a), .mic_b(mic_b), .enable(enable),
    .direction(direction), .rotate(rotate), .move(move), .lead(lead), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
  endtask

  // drives the second mic d cycles after the first; optionally queues the expected episode
  task automatic pair(input bit aFirst, input int d, input bit push);
    episodeT e;
    e.lead = (d <= EQUAL_WIN) ? 2'b11 : (aFirst ? 2'b01 : 2'b10);
    e.rot = (d <= EQUAL_WIN) ? 0 : d * GAIN;
    e.dir = aFirst;
    e.fwd = FWD_CYC;
    if (push) expQ.push_back(e);
    @(posedge clk); #1;
    if (aFirst) mic_a = 1'b1; else mic_b = 1'b1;
    repeat (d) begin @(posedge clk); #1; end
    if (aFirst) mic_b = 1'b1; else mic_a = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    mic_a = 1'b0;
    mic_b = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin @(negedge clk); n++; end
    if (expQ.size() != 0) begin
      check("drain", expQ.size(), 0);
      expQ.delete();
    end
  endtask

  task automatic waitFor(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (state_o !== st && n < budget);
    if (state_o !== st) check(tag, state_o, st);
  endtask

  initial begin
    episodeT e;
    bit inEp, bad;
    logic [1:0] epLead;
    logic rDir;
    int rCnt, fCnt;
    inEp = 0;
    forever begin
      @(negedge clk);
      if (!monOn || !rst_n) inEp = 0;
      else if (move) begin
        if (!inEp) begin
          inEp = 1;
          epLead = lead;
          rDir = direction;
          rCnt = 0;
          fCnt = 0;
          bad = 0;
        end
        if (rotate) begin
          rCnt++;
          if (direction !== rDir || fCnt > 0) bad = 1;
        end else begin
          fCnt++;
          if (direction !== 1'b1) bad = 1;
        end
      end else if (inEp) begin
        inEp = 0;
        if (expQ.size() == 0) check("unexpected_move", rCnt + fCnt, 0);
        else begin
          e = expQ.pop_front();
          check("ep_lead", epLead, e.lead);
          check("ep_rot_cycles", rCnt, e.rot);
          if (e.rot > 0) check("ep_rot_dir", rDir, e.dir);
          check("ep_fwd_cycles", fCnt, e.fwd);
          check("ep_shape", bad, 0);
        end
      end
    end
  end

  initial begin
    int n;
    episodeT e;
    rst_n = 1'b0;
    enable = 1'b1;
    mic_a = 1'b0;
    mic_b = 1'b0;
    #12;
    check("rst_state", state_o, 0);
    check("rst_lead", lead, 0);
    check("rst_move", move, 0);
    check("rst_rotate", rotate, 0);
    check("rst_dir", direction, 0);
    @(negedge clk);
    rst_n = 1'b1;

    pair(1'b1, 5, 1'b1); waitDrain(100);
    pair(1'b0, 3, 1'b1); waitDrain(100);
    pair(1'b1, 0, 1'b1); waitDrain(100);
    pair(1'b1, 1, 1'b1); waitDrain(100);
    pair(1'b0, 7, 1'b1); waitDrain(100);

    // a repeat edge from the leading mic restarts the delay measurement
    e = '{lead: 2'b01, rot: 3 * GAIN, dir: 1'b1, fwd: FWD_CYC};
    expQ.push_back(e);
    @(posedge clk); #1 mic_a = 1'b1;
    repeat (2) @(posedge clk); #1 mic_a = 1'b0;
    repeat (2) @(posedge clk); #1 mic_a = 1'b1;
    repeat (3) @(posedge clk); #1 mic_b = 1'b1;
    repeat (2) @(posedge clk); #1 begin mic_a = 1'b0; mic_b = 1'b0; end
    waitDrain(100);

    @(posedge clk); #1 mic_a = 1'b1;
    repeat (2) @(posedge clk); #1 mic_a = 1'b0;
    waitFor(3'd1, 20, "armed_start");
    n = 0;
    while (state_o == 3'd1 && n < 300) begin n++; @(negedge clk); end
    check("timeout_len", n, TIMEOUT_CYC);
    check("timeout_state", state_o, 0);
    check("timeout_lead", lead, 0);

    e = '{lead: 2'b00, rot: SEARCH_CYC, dir: 1'b1, fwd: 0};
    expQ.push_back(e);
    n = 0;
    while (state_o == 3'd0 && n < 300) begin n++; @(negedge clk); end
    check("idle_len", n, SEARCH_IDLE);
    n = 0;
    while (state_o == 3'd4 && n < 100) begin n++; @(negedge clk); end
    check("search_len", n, SEARCH_CYC);
    check("search_end_state", state_o, 0);

    // time mic_a so its edge is seen in the third search cycle
    e = '{lead: 2'b00, rot: 3, dir: 1'b1, fwd: 0};
    expQ.push_back(e);
    repeat (SEARCH_IDLE - 1) @(negedge clk);
    check("idle_before_abort", state_o, 0);
    mic_a = 1'b1;
    @(negedge clk);
    mic_a = 1'b0;
    n = 0;
    while (state_o == 3'd4 && n < 20) begin n++; @(negedge clk); end
    check("abort_cycle", n, 3);
    check("abort_state", state_o, 1);
    check("abort_move", move, 0);
    check("abort_lead", lead, 1);
    waitDrain(20);
    waitFor(3'd0, 150, "abort_timeout");

    monOn = 0;
    pair(1'b1, 0, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!move && n < 40);
    repeat (3) @(posedge clk);
    #1 check("fwd_before_rst", move, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_move", move, 0);
    check("rst_mid_state", state_o, 0);
    check("rst_mid_lead", lead, 0);
    @(negedge clk);
    rst_n = 1'b1;
    monOn = 1;
    repeat (10) @(negedge clk);
    check("post_rst_state", state_o, 0);

    monOn = 0;
    pair(1'b1, 5, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!rotate && n < 40);
    repeat (2) @(posedge clk);
    #1 check("rot_before_en", rotate, 1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("en_state", state_o, 0);
    check("en_move", move, 0);
    check("en_rotate", rotate, 0);
    check("en_dir", direction, 0);
    check("en_lead", lead, 0);
    enable = 1'b1;
    monOn = 1;
    repeat (10) @(negedge clk);
    check("post_en_state", state_o, 0);
    check("queue_empty", expQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/tdoa_localizer.md
TDOA_LOCALIZER -- requirements
Module: tdoa_localizer

Interface
REQ-001 Parameter TIMER_W, default 16, width of the inter-mic delay timer.
REQ-002 Parameter TIMEOUT_CYC, default 13000, max cycles to wait for the second mic edge.
REQ-003 Parameter EQUAL_WIN, default 0, delay (cycles) at or below which arrival is treated as simultaneous.
REQ-004 Parameter GAIN, default 9000, rotate cycles per cycle of measured delay.
REQ-005 Parameter MOVE_W, default 27, width of the movement countdown.
REQ-006 Parameter FWD_CYC, default 300000, forward-drive cycles after every localization.
REQ-007 Parameter SEARCH_EN, default 1; 1 enables idle search spin.
REQ-008 Parameter SEARCH_IDLE, default 2^24-1, idle cycles with no edge before search starts.
REQ-009 Parameter SEARCH_CYC, default 2^22, cycles per search spin.
REQ-010 clk  input  1  sole clock, rising edge.
REQ-011 rst_n  input  1  asynchronous active-low reset.
REQ-012 mic_a  input  1  asynchronous tone-detect pulse, left mic.
REQ-013 mic_b  input  1  asynchronous tone-detect pulse, right mic.
REQ-014 enable  input  1  synchronous run enable; 0 forces IDLE.
REQ-015 direction  output  1  motor direction (1 = left/forward, 0 = right).
REQ-016 rotate  output  1  1 = spin in place, 0 = straight.
REQ-017 move  output  1  motor drive enable.
REQ-018 lead  output  2  00 none, 01 A first, 10 B first, 11 simultaneous; valid from capture until return to IDLE.
REQ-019 state_o  output  3  current FSM state code (IDLE 0, ARMED 1, ROTATE 2, FORWARD 3, SEARCH 4).

Function
REQ-020 Each mic SHALL pass a 2-flop synchronizer; a rising-edge pulse SHALL be registered one cycle later (pin-to-pulse latency 3 cycles).
REQ-021 IDLE: edge_a and edge_b same cycle -> FORWARD, lead=11, count=FWD_CYC; single edge -> ARMED, lead=01/10, timer=0.
REQ-022 ARMED: timer SHALL increment by 1 per cycle, saturating at 2^TIMER_W-1.
REQ-023 ARMED: edge from the non-leading mic -> delta = timer value that cycle; delta <= EQUAL_WIN -> FORWARD (lead=11, count=FWD_CYC); else -> ROTATE, count = delta*GAIN computed at full product width, saturated to 2^MOVE_W-1.
REQ-024 ARMED: repeat edge from leading mic (without the other) SHALL restart timer at 0, lead unchanged; both edges same cycle -> FORWARD, lead=11.
REQ-025 ARMED: timer reaching TIMEOUT_CYC with no second edge -> IDLE, lead=00.
REQ-026 ROTATE: move=1, rotate=1, direction=1 if lead=01 else 0; count decrements per cycle; at count==1 -> FORWARD with count=FWD_CYC.
REQ-027 FORWARD: move=1, rotate=0, direction=1; count decrements; at count==1 -> IDLE, move=0 the following cycle, lead=00.
REQ-028 Mic edges in ROTATE/FORWARD SHALL be ignored.
REQ-029 SEARCH_EN=1: idle counter counts cycles in IDLE with no edge, cleared on any edge or state exit; reaching SEARCH_IDLE -> SEARCH.
REQ-030 SEARCH: move=1, rotate=1, direction=1 for SEARCH_CYC cycles then IDLE; any edge aborts SEARCH and is processed exactly as in IDLE that cycle.
REQ-031 IDLE/ARMED: move=0, rotate=0, direction=0.
REQ-032 enable=0 SHALL force IDLE next cycle, clear counters, lead=00, and hold all motor outputs 0.
REQ-033 Outputs SHALL be registered (no combinational path from inputs).

Reset
REQ-034 rst_n=0 SHALL asynchronously set state IDLE, all counters, synchronizers and outputs to 0, lead=00.
REQ-035 Reset asserted mid-ROTATE/FORWARD SHALL drop move to 0 immediately; after release the block SHALL wait for a fresh edge.

Verification (GAIN=4, FWD_CYC=10, TIMEOUT_CYC=100, EQUAL_WIN=0, SEARCH_IDLE=50, SEARCH_CYC=8)
REQ-036 mic_a rise, mic_b rise 5 cycles later -> lead=01, ROTATE 20 cycles direction=1, then FORWARD 10 cycles, then move=0.
REQ-037 mic_b rise, mic_a 3 cycles later -> lead=10, direction=0 for 12 rotate cycles, then 10 forward.
REQ-038 Both mics rise same cycle -> lead=11, FORWARD 10 cycles, rotate never 1.
REQ-039 mic_a only -> after 100 cycles return to IDLE, lead=00, move never 1.
REQ-040 No edges 50 cycles -> SEARCH 8 cycles rotate=1; mic_a edge at search cycle 3 -> ARMED, move=0.
REQ-041 rst_n low during FORWARD -> move=0 same cycle; enable=0 during ROTATE -> IDLE next cycle.
